alu_cmd_sequencer: RTL and testbench

Command-side initiator for the 16-bit ALU: accepts operation requests through a valid/ready command port, buffers them in a small FIFO, and drives the ALU's `start`/`op`/`A`/`B` handshake one operation at a time. It captures `Z_high`/`Z_low` when the result is ready and returns it on a valid/ready response port. It sits between a host (CPU bus bridge or test sequencer) and the ALU. It replaces hand-timed stimulus with a protocol-correct driver for single-cycle and multi-cycle (MUL/DIV) operations.

---
 rtl/alu_seq_pkg.sv | 45 ++++
 rtl/alu_cmd_fifo.sv | 80 ++++++++
 rtl/alu_cmd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer:
//   - ALU opcode constants (OP_ADD .. OP_ROR)
//   - cmd_t : one queued command (opcode + operand A + operand B, 36 bits)
//   - state_t : sequencer FSM state encoding
//   - is_multicycle() : true for opcodes that complete via alu_valid
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOT = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_SAR = 4'b1010;
   localparam logic [3:0] OP_CMP = 4'b1011;
   localparam logic [3:0] OP_ROL = 4'b1100;
   localparam logic [3:0] OP_ROR = 4'b1101;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_SC,
      ST_WAIT_MC,
      ST_RESP
   } state_t;

   // MUL and DIV finish on alu_valid; everything else completes in fixed time.
   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous command FIFO, DEPTH entries of cmd_t (36 bits).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   push, wr_data     : write request; ignored while full
//   pop               : read request; ignored while empty
//   rd_data           : head entry, registered on pop and held until next pop
//   full, empty       : registered status flags
// -----------------------------------------------------------------------------
module alu_cmd_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  cmd_t wr_data,
   input  logic pop,
   output cmd_t rd_data,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg, count_next;
   logic          full_reg, empty_reg;
   cmd_t          rd_data_reg;
   logic          do_push, do_pop;

   assign do_push = push && !full_reg;
   assign do_pop  = pop && !empty_reg;

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Storage array carries no reset so it can map onto RAM resources.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         full_reg    <= 1'b0;
         empty_reg   <= 1'b1;
         rd_data_reg <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop) begin
            rd_data_reg <= mem[rd_ptr_reg];
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
         full_reg  <= (count_next == FULL_CNT);
         empty_reg <= (count_next == '0);
      end
   end

   assign rd_data = rd_data_reg;
   assign full    = full_reg;
   assign empty   = empty_reg;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Buffers host ALU commands in a FIFO and drives the ALU start/op/A/B
// handshake one operation at a time, returning each captured result on a
// valid/ready response port.
// Optional build macro: ALU_SEQ_TIMEOUT_EN -- adds a wait counter on MUL/DIV;
// after TIMEOUT cycles without alu_valid the response is returned with
// rsp_err = 1 and a zero result. Without it rsp_err is constant 0.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake (ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b           : command opcode and operands
//   alu_start, alu_op, alu_a/b     : ALU request (start is a 1-cycle pulse)
//   alu_z_low/high, alu_valid      : ALU result and multi-cycle completion
//   rsp_valid/rsp_ready            : response handshake
//   rsp_op, rsp_z_low/high, rsp_err: response payload
//   busy                           : operation in flight or commands queued
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int SC_LAT = 1
`ifdef ALU_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 64
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic        alu_start,
   output logic [3:0]  alu_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_z_low,
   input  logic [15:0] alu_z_high,
   input  logic        alu_valid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [3:0]  rsp_op,
   output logic [15:0] rsp_z_low,
   output logic [15:0] rsp_z_high,
   output logic        rsp_err,
   output logic        busy
);

   localparam int SCW = (SC_LAT > 1) ? $clog2(SC_LAT) : 1;
   localparam logic [SCW-1:0] SC_LAST = SCW'(SC_LAT - 1);

   cmd_t   fifo_wr_data;
   cmd_t   cmd_head;
   logic   fifo_full, fifo_empty, fifo_pop;
   state_t state_reg, state_next;
   logic   capture;

   logic [SCW-1:0] sc_cnt_reg;
   logic [15:0]    rsp_z_low_reg, rsp_z_high_reg;
   logic [3:0]     rsp_op_reg;

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
   logic [TOW-1:0] to_cnt_reg;
   logic           timeout_hit;
   logic           rsp_err_reg;
`endif

   assign fifo_wr_data = '{op: cmd_op, a: cmd_a, b: cmd_b};

   // The FIFO read register doubles as the operand register: it is loaded
   // only on the IDLE pop, so op/A/B stay stable through the whole operation
   // and keep their last value afterwards.
   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (cmd_valid),
      .wr_data (fifo_wr_data),
      .pop     (fifo_pop),
      .rd_data (cmd_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign cmd_ready = !fifo_full;
   assign alu_op    = cmd_head.op;
   assign alu_a     = cmd_head.a;
   assign alu_b     = cmd_head.b;

   always_comb begin
      state_next = state_reg;
      fifo_pop   = 1'b0;
      capture    = 1'b0;
      alu_start  = 1'b0;
      rsp_valid  = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alu_start  = 1'b1;
            state_next = is_multicycle(cmd_head.op) ? ST_WAIT_MC : ST_WAIT_SC;
         end
         ST_WAIT_SC: begin
            if (sc_cnt_reg == SC_LAST) begin
               capture    = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_WAIT_MC: begin
            if (alu_valid) begin
               capture    = 1'b1;
               state_next = ST_RESP;
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            else if (to_cnt_reg == TO_LAST) begin
               timeout_hit = 1'b1;
               state_next  = ST_RESP;
            end
`endif
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         sc_cnt_reg     <= '0;
         rsp_z_low_reg  <= '0;
         rsp_z_high_reg <= '0;
         rsp_op_reg     <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
         to_cnt_reg     <= '0;
         rsp_err_reg    <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         // Counters run only while waiting and restart from zero on entry.
         sc_cnt_reg <= (state_reg == ST_WAIT_SC) ? sc_cnt_reg + 1'b1 : '0;
`ifdef ALU_SEQ_TIMEOUT_EN
         to_cnt_reg <= (state_reg == ST_WAIT_MC) ? to_cnt_reg + 1'b1 : '0;
`endif
         if (capture) begin
            rsp_z_low_reg  <= alu_z_low;
            rsp_z_high_reg <= alu_z_high;
            rsp_op_reg     <= cmd_head.op;
`ifdef ALU_SEQ_TIMEOUT_EN
            rsp_err_reg    <= 1'b0;
`endif
         end
`ifdef ALU_SEQ_TIMEOUT_EN
         if (timeout_hit) begin
            rsp_z_low_reg  <= '0;
            rsp_z_high_reg <= '0;
            rsp_op_reg     <= cmd_head.op;
            rsp_err_reg    <= 1'b1;
         end
`endif
      end
   end

   assign rsp_op     = rsp_op_reg;
   assign rsp_z_low  = rsp_z_low_reg;
   assign rsp_z_high = rsp_z_high_reg;
`ifdef ALU_SEQ_TIMEOUT_EN
   assign rsp_err    = rsp_err_reg;
`else
   assign rsp_err    = 1'b0;
`endif
   assign busy       = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
   import alu_seq_pkg::*;

   localparam int DEPTH       = 4;
   localparam int SC_LAT      = 1;
   localparam int TIMEOUT_CYC = 64;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] zl;
      logic [15:0] zh;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = 4'h0;
   logic [15:0] cmd_a = 16'h0;
   logic [15:0] cmd_b = 16'h0;
   logic        alu_start;
   logic [3:0]  alu_op;
   logic [15:0] alu_a, alu_b;
   logic [15:0] alu_z_low, alu_z_high;
   logic        alu_valid;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [3:0]  rsp_op;
   logic [15:0] rsp_z_low, rsp_z_high;
   logic        rsp_err;
   logic        busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];
   int   start_cnt = 0;
   int   valid_cnt = 0;

   // behavioural ALU model state
   int          mc_cnt = 0;
   bit          suppress_valid = 1'b0;
   logic [15:0] m_zl = 16'h0;
   logic [15:0] m_zh = 16'h0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .DEPTH  (DEPTH),
      .SC_LAT (SC_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_z_low  (alu_z_low),
      .alu_z_high (alu_z_high),
      .alu_valid  (alu_valid),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_op     (rsp_op),
      .rsp_z_low  (rsp_z_low),
      .rsp_z_high (rsp_z_high),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Reference ALU arithmetic: returns {z_high, z_low}.
   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] p;
      logic signed [15:0] q, r;
      alu_ref = 32'h0;
      case (op)
         OP_ADD: alu_ref = {16'h0, a + b};
         OP_SUB: alu_ref = {16'h0, a - b};
         OP_MUL: begin
            p = $signed(a) * $signed(b);
            alu_ref = p;
         end
         OP_DIV: begin
            if (b == 16'h0) alu_ref = {a, 16'hFFFF};
            else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               alu_ref = {r, q};
            end
         end
         OP_XOR: alu_ref = {16'h0, a ^ b};
         OP_SHL: alu_ref = {16'h0, a << b[3:0]};
         default: alu_ref = 32'h0;
      endcase
   endfunction

   assign alu_z_low  = m_zl;
   assign alu_z_high = m_zh;
   assign alu_valid  = (mc_cnt == 1) && !suppress_valid;

   // MUL: valid 16 cycles after start; DIV: 17, or 1 when B = 0.
   always @(posedge clk) begin
      if (alu_start) begin
         {m_zh, m_zl} <= alu_ref(alu_op, alu_a, alu_b);
         if (alu_op == OP_MUL)      mc_cnt <= 16;
         else if (alu_op == OP_DIV) mc_cnt <= (alu_b == 16'h0) ? 1 : 17;
         else                       mc_cnt <= 0;
      end else if (mc_cnt > 0) begin
         mc_cnt <= mc_cnt - 1;
      end
   end

   always @(posedge clk) begin
      if (alu_start === 1'b1) start_cnt <= start_cnt + 1;
      if (alu_valid === 1'b1) valid_cnt <= valid_cnt + 1;
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output bit ok);
      ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      for (int w = 0; w < 200; w++) begin
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Waits for a response with rsp_ready high; cyc counts negedges since accept.
   task automatic get_rsp(input int limit, output bit ok, output int cyc, output exp_t got);
      ok = 1'b0;
      cyc = 1;
      got = '{4'h0, 16'h0, 16'h0, 1'b0};
      rsp_ready = 1'b1;
      while (cyc <= limit) begin
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            got = '{rsp_op, rsp_z_low, rsp_z_high, rsp_err};
            break;
         end
         @(negedge clk);
         cyc++;
      end
      if (ok) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({alu_start, rsp_valid, busy, rsp_err} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b required 0000", {alu_start, rsp_valid, busy, rsp_err});
      end
      n_cmp++;
      if ({alu_op, alu_a, alu_b} !== 36'h0) begin
         n_bad++;
         $display("FAIL reset_alu_bus: got %h required 0", {alu_op, alu_a, alu_b});
      end
      n_cmp++;
      if ({rsp_op, rsp_z_high, rsp_z_low} !== 36'h0) begin
         n_bad++;
         $display("FAIL reset_rsp_bus: got %h required 0", {rsp_op, rsp_z_high, rsp_z_low});
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({cmd_ready, busy} !== 2'b10) begin
         n_bad++;
         $display("FAIL reset_release: got ready/busy %b required 10", {cmd_ready, busy});
      end
      $display("reset: done");
   endtask

   task automatic test_add();
      exp_t got, e;
      bit ok;
      int cyc, s0;
      s0 = start_cnt;
      sb.push_back('{OP_ADD, 16'h007D, 16'h0000, 1'b0});
      push_cmd(OP_ADD, 16'd100, 16'd25, ok);
      get_rsp(200, ok, cyc, got);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL add_rsp: got no response required one within 200 cycles");
      end else if ({got.op, got.zh, got.zl, got.err} !== {e.op, e.zh, e.zl, e.err}) begin
         n_bad++;
         $display("FAIL add_rsp: got %h required %h", {got.op, got.zh, got.zl, got.err}, {e.op, e.zh, e.zl, e.err});
      end
      n_cmp++;
      if (cyc != 2 + SC_LAT + 1) begin
         n_bad++;
         $display("FAIL add_latency: got %0d required %0d", cyc, 2 + SC_LAT + 1);
      end
      n_cmp++;
      if (start_cnt - s0 != 1) begin
         n_bad++;
         $display("FAIL add_starts: got %0d required 1", start_cnt - s0);
      end
      $display("add: op=%h z=%h_%h err=%b latency=%0d", got.op, got.zh, got.zl, got.err, cyc);
   endtask

   task automatic test_mul();
      exp_t got, e;
      bit ok;
      int cyc, v0;
      v0 = valid_cnt;
      sb.push_back('{OP_MUL, 16'h9500, 16'h0ABA, 1'b0});
      push_cmd(OP_MUL, 16'hC568, 16'hD120, ok);  // -15000 x -12000
      get_rsp(200, ok, cyc, got);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL mul_rsp: got no response required one within 200 cycles");
      end else if ({got.op, got.zh, got.zl, got.err} !== {e.op, e.zh, e.zl, e.err}) begin
         n_bad++;
         $display("FAIL mul_rsp: got %h required %h", {got.op, got.zh, got.zl, got.err}, {e.op, e.zh, e.zl, e.err});
      end
      n_cmp++;
      if (cyc != 2 + 16 + 1) begin
         n_bad++;
         $display("FAIL mul_latency: got %0d required %0d", cyc, 2 + 16 + 1);
      end
      n_cmp++;
      if (valid_cnt - v0 != 1) begin
         n_bad++;
         $display("FAIL mul_valid_before_rsp: got %0d pulses required 1", valid_cnt - v0);
      end
      $display("mul: op=%h z=%h_%h err=%b latency=%0d", got.op, got.zh, got.zl, got.err, cyc);
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops[5];
      logic [15:0] as[5], bs[5];
      logic [31:0] r;
      exp_t got, e;
      bit ok;
      int cyc, s0;
      ops = '{OP_ADD, OP_MUL, OP_SUB, OP_DIV, OP_XOR};
      for (int i = 0; i < 5; i++) begin
         as[i] = 16'($urandom_range(0, 30000));
         bs[i] = 16'($urandom_range(1, 1000));
      end
      bs[3] = 16'h0;  // DIV by zero takes the short completion path
      rsp_ready = 1'b0;
      s0 = start_cnt;
      for (int i = 0; i < 5; i++) begin
         r = alu_ref(ops[i], as[i], bs[i]);
         sb.push_back('{ops[i], r[15:0], r[31:16], 1'b0});
         push_cmd(ops[i], as[i], bs[i], ok);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL b2b_accept_%0d: got not accepted required accepted", i);
         end
      end
      n_cmp++;
      if ({rsp_valid, cmd_ready, busy} !== 3'b101) begin
         n_bad++;
         $display("FAIL b2b_full: got valid/ready/busy %b required 101", {rsp_valid, cmd_ready, busy});
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (start_cnt - s0 != 1 || cmd_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_stall: got starts=%0d ready=%b required starts=1 ready=0", start_cnt - s0, cmd_ready);
      end
      for (int i = 0; i < 5; i++) begin
         get_rsp(200, ok, cyc, got);
         e = sb.pop_front();
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL b2b_rsp_%0d: got no response required one within 200 cycles", i);
         end else if ({got.op, got.zh, got.zl, got.err} !== {e.op, e.zh, e.zl, e.err}) begin
            n_bad++;
            $display("FAIL b2b_rsp_%0d: got %h required %h", i, {got.op, got.zh, got.zl, got.err}, {e.op, e.zh, e.zl, e.err});
         end
         $display("b2b[%0d]: op=%h z=%h_%h err=%b", i, got.op, got.zh, got.zl, got.err);
      end
   endtask

   task automatic test_backpressure();
      exp_t got, e;
      bit ok, ok2;
      int cyc, s0, w;
      rsp_ready = 1'b0;
      sb.push_back('{OP_SHL, 16'hF0F0, 16'h0000, 1'b0});
      sb.push_back('{OP_ADD, 16'h0003, 16'h0000, 1'b0});
      push_cmd(OP_SHL, 16'h0F0F, 16'h0004, ok);
      push_cmd(OP_ADD, 16'h0001, 16'h0002, ok2);
      w = 0;
      while (rsp_valid !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_first_rsp: got rsp_valid=%b required 1", rsp_valid);
      end
      s0 = start_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({rsp_valid, rsp_op, rsp_z_low} !== {1'b1, OP_SHL, 16'hF0F0}) begin
            n_bad++;
            $display("FAIL bp_hold_%0d: got %h required %h", i, {rsp_valid, rsp_op, rsp_z_low}, {1'b1, OP_SHL, 16'hF0F0});
         end
      end
      n_cmp++;
      if (start_cnt != s0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_no_issue: got extra starts=%0d busy=%b required 0 and 1", start_cnt - s0, busy);
      end
      for (int i = 0; i < 2; i++) begin
         get_rsp(200, ok, cyc, got);
         e = sb.pop_front();
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL bp_rsp_%0d: got no response required one within 200 cycles", i);
         end else if ({got.op, got.zh, got.zl, got.err} !== {e.op, e.zh, e.zl, e.err}) begin
            n_bad++;
            $display("FAIL bp_rsp_%0d: got %h required %h", i, {got.op, got.zh, got.zl, got.err}, {e.op, e.zh, e.zl, e.err});
         end
         $display("backpressure[%0d]: op=%h z=%h_%h err=%b", i, got.op, got.zh, got.zl, got.err);
      end
   endtask

   task automatic test_reset_mid();
      exp_t got, e;
      bit ok, seen;
      int cyc, w, v0;
      rsp_ready = 1'b1;
      push_cmd(OP_DIV, 16'd1000, 16'd7, ok);
      w = 0;
      while (alu_start !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (alu_start !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_start: got alu_start=%b required 1", alu_start);
      end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      v0 = valid_cnt;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (valid_cnt - v0 != 1 || seen) begin
         n_bad++;
         $display("FAIL rstmid_no_rsp: got valid pulses=%0d rsp_seen=%b required 1 and 0", valid_cnt - v0, seen);
      end
      n_cmp++;
      if ({busy, cmd_ready, rsp_z_low} !== {1'b0, 1'b1, 16'h0}) begin
         n_bad++;
         $display("FAIL rstmid_idle: got busy/ready/zl %h required %h", {busy, cmd_ready, rsp_z_low}, {1'b0, 1'b1, 16'h0});
      end
      sb.push_back('{OP_ADD, 16'h000F, 16'h0000, 1'b0});
      push_cmd(OP_ADD, 16'd7, 16'd8, ok);
      get_rsp(200, ok, cyc, got);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL rstmid_recover: got no response required one within 200 cycles");
      end else if ({got.op, got.zh, got.zl, got.err} !== {e.op, e.zh, e.zl, e.err}) begin
         n_bad++;
         $display("FAIL rstmid_recover: got %h required %h", {got.op, got.zh, got.zl, got.err}, {e.op, e.zh, e.zl, e.err});
      end
      $display("reset_mid: recovery op=%h z=%h_%h err=%b", got.op, got.zh, got.zl, got.err);
   endtask

`ifdef ALU_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      exp_t got, e;
      bit ok;
      int cyc;
      suppress_valid = 1'b1;
      sb.push_back('{OP_MUL, 16'h0000, 16'h0000, 1'b1});
      push_cmd(OP_MUL, 16'd100, 16'd200, ok);
      get_rsp(300, ok, cyc, got);
      e = sb.pop_front();
      suppress_valid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL timeout_rsp: got no response required one within 300 cycles");
      end else if ({got.op, got.zh, got.zl, got.err} !== {e.op, e.zh, e.zl, e.err}) begin
         n_bad++;
         $display("FAIL timeout_rsp: got %h required %h", {got.op, got.zh, got.zl, got.err}, {e.op, e.zh, e.zl, e.err});
      end
      n_cmp++;
      if (cyc != 2 + TIMEOUT_CYC + 1) begin
         n_bad++;
         $display("FAIL timeout_latency: got %0d required %0d", cyc, 2 + TIMEOUT_CYC + 1);
      end
      $display("timeout: op=%h z=%h_%h err=%b latency=%0d", got.op, got.zh, got.zl, got.err, cyc);
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
`ifdef ALU_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
